// File: rtl/negedge_capture_serial_tx.sv
// negedge_capture_serial_tx
// Parallel-to-serial transmitter. Bits are launched on CLK rising edges and
// held for the following falling edge, where a downstream negedge-capture
// chain samples them mid-cycle. valid/ready on the parallel side,
// SDO + BIT_EN + FRAME on the serial side.
// Optional even-parity trailer bit: define GF180MCU_FD_SC_MCU9T5V0__SERTX_PARITY_EN.
module negedge_capture_serial_tx #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic             SDO,
  output logic             BIT_EN,
  output logic             FRAME,
  output logic             BUSY
);

`ifdef GF180MCU_FD_SC_MCU9T5V0__SERTX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam logic [5:0] LAST_IDX   = 6'(FRAME_LEN - 1);
  localparam logic [5:0] DATA_BITS  = 6'(WIDTH);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_shift;
  logic [5:0]       r_bit_cnt;
  logic [3:0]       r_gap_cnt;
  logic             r_sdo;
  logic             r_bit_en;
  logic             r_frame;

  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [5:0]       w_bit_cnt_nxt;
  logic [5:0]       w_bit_idx;
  logic [3:0]       w_gap_cnt_nxt;
  logic             w_sdo_nxt;
  logic             w_bit_en_nxt;
  logic             w_frame_nxt;
  logic             w_accept;
  logic             w_par_bit;

  assign w_accept  = (r_state == S_IDLE) && TX_VALID;
  assign w_shifted = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
  assign w_bit_idx = r_bit_cnt + 6'd1;

`ifdef GF180MCU_FD_SC_MCU9T5V0__SERTX_PARITY_EN
  logic r_parity;

  // Even parity of the accepted word, frozen for the trailer bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_parity <= 1'b0;
    else if (w_accept) r_parity <= ^TX_DATA;
  end

  assign w_par_bit = r_parity;
`else
  assign w_par_bit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus next values of the datapath and the registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_sdo_nxt     = 1'b0;
    w_bit_en_nxt  = 1'b0;
    w_frame_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (TX_VALID) begin
          w_state_nxt   = S_SHIFT;
          w_shift_nxt   = TX_DATA;
          w_bit_cnt_nxt = '0;
          w_gap_cnt_nxt = '0;
          w_sdo_nxt     = (MSB_FIRST != 0) ? TX_DATA[WIDTH-1] : TX_DATA[0];
          w_bit_en_nxt  = 1'b1;
          w_frame_nxt   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == LAST_IDX) begin
          w_state_nxt   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_shift_nxt   = w_shifted;
          w_bit_cnt_nxt = w_bit_idx;
          w_bit_en_nxt  = 1'b1;
          w_frame_nxt   = 1'b1;
          // Data bits come off the shifter; the slot past the data is parity.
          if (w_bit_idx < DATA_BITS)
            w_sdo_nxt = (MSB_FIRST != 0) ? w_shifted[WIDTH-1] : w_shifted[0];
          else
            w_sdo_nxt = w_par_bit;
        end
      end
      S_GAP: begin
        w_gap_cnt_nxt = r_gap_cnt + 4'd1;
        if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and serial outputs; all launched on the rising edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sdo     <= 1'b0;
      r_bit_en  <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_sdo     <= w_sdo_nxt;
      r_bit_en  <= w_bit_en_nxt;
      r_frame   <= w_frame_nxt;
    end
  end

  assign SDO      = r_sdo;
  assign BIT_EN   = r_bit_en;
  assign FRAME    = r_frame;
  assign TX_READY = (r_state == S_IDLE);
  assign BUSY     = (r_state != S_IDLE);

endmodule

// File: tb/tb_negedge_capture_serial_tx.sv
// Bench for negedge_capture_serial_tx. Two instances: A (MSB first, GAP=1)
// and B (LSB first, GAP=0). Outputs are sampled on falling edges, as the
// downstream capture chain would.
module tb_negedge_capture_serial_tx;

`ifdef GF180MCU_FD_SC_MCU9T5V0__SERTX_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_valid, a_ready, a_sdo, a_bit_en, a_frame, a_busy;
  logic [7:0] a_data;
  logic       b_rst, b_valid, b_ready, b_sdo, b_bit_en, b_frame, b_busy;
  logic [7:0] b_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  negedge_capture_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1)) dut_a (
    .CLK(clk), .RST(a_rst), .TX_DATA(a_data), .TX_VALID(a_valid),
    .TX_READY(a_ready), .SDO(a_sdo), .BIT_EN(a_bit_en), .FRAME(a_frame),
    .BUSY(a_busy)
  );

  negedge_capture_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_b (
    .CLK(clk), .RST(b_rst), .TX_DATA(b_data), .TX_VALID(b_valid),
    .TX_READY(b_ready), .SDO(b_sdo), .BIT_EN(b_bit_en), .FRAME(b_frame),
    .BUSY(b_busy)
  );

  task automatic test_reset();
    logic [4:0] got;
    a_rst = 1'b1; b_rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0;
    repeat (2) @(negedge clk);
    got = {a_sdo, a_bit_en, a_frame, a_busy, a_ready};
    total_cnt++;
    if (got !== 5'b00001) $display("FAIL reset_a_held got=%b exp=00001", got);
    else pass_cnt++;
    got = {b_sdo, b_bit_en, b_frame, b_busy, b_ready};
    total_cnt++;
    if (got !== 5'b00001) $display("FAIL reset_b_held got=%b exp=00001", got);
    else pass_cnt++;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    got = {a_sdo, a_bit_en, a_frame, a_busy, a_ready};
    total_cnt++;
    if (got !== 5'b00001) $display("FAIL reset_a_released got=%b exp=00001", got);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic [4:0] got;
    logic       exp_bit;
    d = 8'hA5;
    a_data = d; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    got = {a_sdo, a_bit_en, a_frame, a_busy, a_ready};
    total_cnt++;
    if (got !== 5'b11110) $display("FAIL single_first got=%b exp=11110", got);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      exp_bit = (i < 8) ? d[7-i] : 1'b0;  // 0xA5 has even weight
      total_cnt++;
      if ({a_sdo, a_bit_en, a_frame} !== {exp_bit, 2'b11})
        $display("FAIL single_bit%0d got=%b%b%b exp=%b11", i, a_sdo, a_bit_en, a_frame, exp_bit);
      else pass_cnt++;
    end
    @(negedge clk);
    got = {a_sdo, a_bit_en, a_frame, a_busy, a_ready};
    total_cnt++;
    if (got !== 5'b00010) $display("FAIL single_gap got=%b exp=00010", got);
    else pass_cnt++;
    @(negedge clk);
    got = {a_sdo, a_bit_en, a_frame, a_busy, a_ready};
    total_cnt++;
    if (got !== 5'b00001) $display("FAIL single_idle got=%b exp=00001", got);
    else pass_cnt++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] rx;
    logic [4:0] got;
    logic       exp_bit;
    int         en_cnt;
    rx = '0; en_cnt = 0;
    b_data = 8'h01; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      if (b_bit_en) en_cnt++;
      if (b_bit_en && i < 8) rx[i] = b_sdo;
      exp_bit = (i == 0) ? 1'b1 : ((i < 8) ? 1'b0 : 1'b1);  // parity of 0x01 is 1
      total_cnt++;
      if (b_sdo !== exp_bit) $display("FAIL lsb_bit%0d got=%b exp=%b", i, b_sdo, exp_bit);
      else pass_cnt++;
    end
    total_cnt++;
    if (rx !== 8'h01) $display("FAIL lsb_rx got=%h exp=01", rx);
    else pass_cnt++;
    total_cnt++;
    if (en_cnt !== N) $display("FAIL lsb_bit_en_count got=%0d exp=%0d", en_cnt, N);
    else pass_cnt++;
    @(negedge clk);
    got = {b_sdo, b_bit_en, b_frame, b_busy, b_ready};
    total_cnt++;
    if (got !== 5'b00001) $display("FAIL lsb_idle_no_gap got=%b exp=00001", got);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] fr, be, sd, exp_fr;
    logic [7:0]  rx1, rx2;
    fr = '0; be = '0; sd = '0; exp_fr = '0;
    for (int s = 0; s < 2 * N + 2; s++)
      if (s != N && s != 2 * N + 1) exp_fr[s] = 1'b1;
    b_data = 8'h3C; b_valid = 1'b1;
    for (int s = 0; s < 2 * N + 2; s++) begin
      @(negedge clk);
      fr[s] = b_frame; be[s] = b_bit_en; sd[s] = b_sdo;
      if (s == 0) b_data = 8'hC3;
      if (s == N + 1) b_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      rx1[i] = sd[i];
      rx2[i] = sd[N + 1 + i];
    end
    total_cnt++;
    if (fr !== exp_fr) $display("FAIL b2b_frame got=%h exp=%h", fr, exp_fr);
    else pass_cnt++;
    total_cnt++;
    if (be !== exp_fr) $display("FAIL b2b_bit_en got=%h exp=%h", be, exp_fr);
    else pass_cnt++;
    total_cnt++;
    if (rx1 !== 8'h3C) $display("FAIL b2b_word1 got=%h exp=3c", rx1);
    else pass_cnt++;
    total_cnt++;
    if (rx2 !== 8'hC3) $display("FAIL b2b_word2 got=%h exp=c3", rx2);
    else pass_cnt++;
  endtask

  task automatic test_midframe_reset();
    logic [7:0] rx;
    logic [4:0] got;
    int         ones;
    ones = 0; rx = '0;
    a_data = 8'hFF; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    if (a_sdo === 1'b1) ones++;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      if (a_sdo === 1'b1) ones++;
    end
    total_cnt++;
    if (ones !== 4) $display("FAIL midrst_prefix got=%0d exp=4", ones);
    else pass_cnt++;
    #1 a_rst = 1'b1;
    #1;
    got = {a_sdo, a_bit_en, a_frame, a_busy, a_ready};
    total_cnt++;
    if (got !== 5'b00001) $display("FAIL midrst_async got=%b exp=00001", got);
    else pass_cnt++;
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    a_data = 8'h81; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 8 && a_bit_en && a_frame) rx[7-i] = a_sdo;
    end
    total_cnt++;
    if (rx !== 8'h81) $display("FAIL midrst_next_word got=%h exp=81", rx);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    got = {a_sdo, a_bit_en, a_frame, a_busy, a_ready};
    total_cnt++;
    if (got !== 5'b00001) $display("FAIL midrst_idle got=%b exp=00001", got);
    else pass_cnt++;
  endtask

  task automatic test_data_change();
    logic [7:0] rx;
    rx = '0;
    a_data = 8'hF0; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; a_data = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 8) rx[7-i] = a_sdo;
    end
    total_cnt++;
    if (rx !== 8'hF0) $display("FAIL data_change got=%h exp=f0", rx);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_len();
    logic [7:0] words [2];
    logic       last_exp [2];
    logic       last_bit;
    int         en_cnt;
    words[0] = 8'h07; last_exp[0] = 1'b1;
    words[1] = 8'h03; last_exp[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      en_cnt = 0; last_bit = 1'bx;
      a_data = words[w]; a_valid = 1'b1;
      for (int s = 0; s < N + 2; s++) begin
        @(negedge clk);
        if (s == 0) a_valid = 1'b0;
        if (a_bit_en === 1'b1) en_cnt++;
        if (s == N - 1) last_bit = a_sdo;
      end
      total_cnt++;
      if (en_cnt !== N) $display("FAIL frame_len_w%0d got=%0d exp=%0d", w, en_cnt, N);
      else pass_cnt++;
`ifdef GF180MCU_FD_SC_MCU9T5V0__SERTX_PARITY_EN
      total_cnt++;
      if (last_bit !== last_exp[w]) $display("FAIL parity_w%0d got=%b exp=%b", w, last_bit, last_exp[w]);
      else pass_cnt++;
`else
      total_cnt++;
      if (last_bit !== words[w][0]) $display("FAIL last_data_w%0d got=%b exp=%b", w, last_bit, words[w][0]);
      else pass_cnt++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_back_to_back();
    test_midframe_reset();
    test_data_change();
    test_frame_len();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
